// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: word-organised data memory with a request/response handshake,
// a configurable access latency and per-byte write enables.
// Build option DMEM_DUMP_EN adds an end-of-execution dump sequencer that
// streams every word once the program has finished. Without it the dump
// ports are inert and tied to zero.
module data_mem_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 8192,
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic                ready,
    output logic                rvalid,
    output logic [DATA_W-1:0]   rdata,
    input  logic                endofexec,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [ADDR_W-1:0]   dump_addr,
    output logic [DATA_W-1:0]   dump_data,
    output logic                dump_done
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DUMP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Storage is deliberately left out of reset: contents survive a reset.
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [1:0]        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              we_r;
    logic [IDX_W-1:0]  idx_r;
    logic [DATA_W-1:0] wdata_r;
    logic [BE_W-1:0]   be_r;
    logic              rvalid_r;
    logic [DATA_W-1:0] rdata_r;
    logic [IDX_W-1:0]  addr_idx_s;
    logic              access_s;
    logic              unused_s;

    assign addr_idx_s = addr[IDX_W+1:2];
    // The access happens on the edge that ends the last wait cycle.
    assign access_s   = (state_r == BUSY) && (cnt_r == CNT_W'(0));
    assign ready      = (state_r == IDLE) && rst_n;
    assign rvalid     = rvalid_r;
    assign rdata      = rdata_r;

`ifdef DMEM_DUMP_EN
    logic             eoe_d_r;
    logic             pend_r;
    logic [IDX_W-1:0] dump_idx_r;
    logic             eoe_rise_s;

    assign eoe_rise_s = endofexec & ~eoe_d_r;
    assign dump_valid = (state_r == DUMP);
    assign dump_done  = (state_r == DONE);
    assign dump_addr  = ADDR_W'({dump_idx_r, 2'b00});
    assign dump_data  = mem_r[dump_idx_r];
    assign unused_s   = &{1'b0, addr};
`else
    assign dump_valid = 1'b0;
    assign dump_done  = 1'b0;
    assign dump_addr  = ADDR_W'(0);
    assign dump_data  = DATA_W'(0);
    assign unused_s   = &{1'b0, addr, endofexec, dump_ready};
`endif

    // Control state machine: request latch, wait counter, completion and dump walk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_W'(0);
            we_r     <= 1'b0;
            idx_r    <= IDX_W'(0);
            wdata_r  <= DATA_W'(0);
            be_r     <= BE_W'(0);
            rvalid_r <= 1'b0;
            rdata_r  <= DATA_W'(0);
`ifdef DMEM_DUMP_EN
            eoe_d_r    <= 1'b0;
            pend_r     <= 1'b0;
            dump_idx_r <= IDX_W'(0);
`endif
        end else begin
            rvalid_r <= 1'b0;
`ifdef DMEM_DUMP_EN
            eoe_d_r  <= endofexec;
`endif
            case (state_r)
                IDLE: begin
`ifdef DMEM_DUMP_EN
                    // An end-of-execution event wins over a same-cycle request.
                    if (eoe_rise_s) begin
                        state_r    <= DUMP;
                        pend_r     <= 1'b0;
                        dump_idx_r <= IDX_W'(0);
                    end else
`endif
                    if (req) begin
                        we_r    <= we;
                        idx_r   <= addr_idx_s;
                        wdata_r <= wdata;
                        be_r    <= be;
                        cnt_r   <= CNT_W'(LATENCY - 1);
                        state_r <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_r == CNT_W'(0)) begin
                        rvalid_r <= 1'b1;
                        if (!we_r) begin
                            rdata_r <= mem_r[idx_r];
                        end
`ifdef DMEM_DUMP_EN
                        if (pend_r || eoe_rise_s) begin
                            state_r    <= DUMP;
                            pend_r     <= 1'b0;
                            dump_idx_r <= IDX_W'(0);
                        end else begin
                            state_r <= IDLE;
                        end
`else
                        state_r <= IDLE;
`endif
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
`ifdef DMEM_DUMP_EN
                        if (eoe_rise_s) begin
                            pend_r <= 1'b1;
                        end
`endif
                    end
                end
`ifdef DMEM_DUMP_EN
                DUMP: begin
                    if (dump_ready) begin
                        if (dump_idx_r == IDX_W'(DEPTH - 1)) begin
                            state_r <= DONE;
                        end else begin
                            dump_idx_r <= dump_idx_r + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_r <= DONE;
                end
`endif
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Byte-masked write commit; a reset edge drops the in-flight write.
    always_ff @(posedge clk) begin
        if (rst_n && access_s && we_r) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be_r[i]) begin
                    mem_r[idx_r][8*i +: 8] <= wdata_r[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl. Instance 0 uses LATENCY=1 with the
// default 8192-word depth; instance 1 uses LATENCY=3 with 16 words so the dump
// stream (when DMEM_DUMP_EN is defined) stays short.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_a  [2];
    logic        req_a  [2];
    logic        we_a   [2];
    logic [15:0] addr_a [2];
    logic [31:0] wd_a   [2];
    logic [3:0]  be_a   [2];
    logic        rdy_a  [2];
    logic        rv_a   [2];
    logic [31:0] rd_a   [2];
    logic        eoe_a  [2];
    logic        dv_a   [2];
    logic        dr_a   [2];
    logic [15:0] da_a   [2];
    logic [31:0] dd_a   [2];
    logic        done_a [2];

    int checks = 0;
    int errors = 0;

    // Reference model: plain word arrays plus the last read value per instance.
    logic [31:0] m0 [8192];
    logic [31:0] m1 [16];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    data_mem_ctrl #(.DATA_W(32), .ADDR_W(16), .DEPTH(8192), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_a[0]), .req(req_a[0]), .we(we_a[0]), .addr(addr_a[0]),
        .wdata(wd_a[0]), .be(be_a[0]), .ready(rdy_a[0]), .rvalid(rv_a[0]), .rdata(rd_a[0]),
        .endofexec(eoe_a[0]), .dump_valid(dv_a[0]), .dump_ready(dr_a[0]),
        .dump_addr(da_a[0]), .dump_data(dd_a[0]), .dump_done(done_a[0]));

    data_mem_ctrl #(.DATA_W(32), .ADDR_W(16), .DEPTH(16), .LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_a[1]), .req(req_a[1]), .we(we_a[1]), .addr(addr_a[1]),
        .wdata(wd_a[1]), .be(be_a[1]), .ready(rdy_a[1]), .rvalid(rv_a[1]), .rdata(rd_a[1]),
        .endofexec(eoe_a[1]), .dump_valid(dv_a[1]), .dump_ready(dr_a[1]),
        .dump_addr(da_a[1]), .dump_data(dd_a[1]), .dump_done(done_a[1]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    // One complete handshake; called and returns at a falling edge.
    task automatic access(input int s, input bit w, input logic [15:0] a,
                          input logic [31:0] wd, input logic [3:0] b, input string tag);
        int n;
        int lat;
        int idx;
        lat = (s == 0) ? 1 : 3;
        idx = (s == 0) ? int'(a[14:2]) : int'(a[5:2]);
        n = 0;
        while (rdy_a[s] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/ready_idle"}, 64'(rdy_a[s]), 64'd1);
        req_a[s] = 1'b1; we_a[s] = w; addr_a[s] = a; wd_a[s] = wd; be_a[s] = b;
        @(posedge clk); #1;
        req_a[s] = 1'b0;
        n = 0;
        while (rv_a[s] !== 1'b1 && n < 20) begin
            chk({tag, "/ready_busy"}, 64'(rdy_a[s]), 64'd0);
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "/latency"}, 64'(n), 64'(lat));
        chk({tag, "/ready_with_rvalid"}, 64'(rdy_a[s]), 64'd1);
        if (w) begin
            if (s == 0) m0[idx] = merge(m0[idx], wd, b);
            else        m1[idx] = merge(m1[idx], wd, b);
        end else begin
            last_rd[s] = (s == 0) ? m0[idx] : m1[idx];
        end
        chk({tag, "/rdata"}, 64'(rd_a[s]), 64'(last_rd[s]));
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int acc_q[$];
        int rv_q[$];
        logic acc_now;
        logic [31:0] old;
        int n;
        int idx_exp;
        bit tog;
        bit xfer;

        for (int s = 0; s < 2; s++) begin
            rst_a[s] = 1'b0; req_a[s] = 1'b0; we_a[s] = 1'b0; addr_a[s] = 16'h0000;
            wd_a[s] = 32'h0; be_a[s] = 4'h0; eoe_a[s] = 1'b0; dr_a[s] = 1'b0;
            last_rd[s] = 32'h0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst/ready", 64'(rdy_a[s]), 64'd0);
            chk("rst/rvalid", 64'(rv_a[s]), 64'd0);
            chk("rst/rdata", 64'(rd_a[s]), 64'd0);
            chk("rst/dump_valid", 64'(dv_a[s]), 64'd0);
            chk("rst/dump_done", 64'(done_a[s]), 64'd0);
        end
        @(negedge clk);
        rst_a[0] = 1'b1; rst_a[1] = 1'b1;
        @(negedge clk);
        chk("post_rst/ready0", 64'(rdy_a[0]), 64'd1);
        chk("post_rst/ready1", 64'(rdy_a[1]), 64'd1);

        // LATENCY=1 directed cases
        access(0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, "wr10");
        access(0, 1'b0, 16'h0010, 32'h0, 4'h0, "rd10");
        chk("rd10/literal", 64'(rd_a[0]), 64'h0000_0000_DEAD_BEEF);
        access(0, 1'b1, 16'h0020, 32'h11223344, 4'hF, "wr20");
        access(0, 1'b1, 16'h0020, 32'hAABBCCDD, 4'b0101, "wr20_be");
        access(0, 1'b0, 16'h0020, 32'h0, 4'h0, "rd20");
        chk("rd20/literal", 64'(rd_a[0]), 64'h0000_0000_11BB_33DD);
        access(0, 1'b1, 16'h8004, 32'h00000005, 4'hF, "wr_wrap");
        access(0, 1'b0, 16'h0004, 32'h0, 4'h0, "rd_wrap");
        chk("rd_wrap/literal", 64'(rd_a[0]), 64'h5);
        access(0, 1'b1, 16'h0010, 32'h12345678, 4'h0, "wr_be0");
        access(0, 1'b0, 16'h0010, 32'h0, 4'h0, "rd_be0");
        chk("rd_be0/literal", 64'(rd_a[0]), 64'h0000_0000_DEAD_BEEF);

        // Randomized traffic over words 16..31 with random wrap bit and byte offset
        for (int i = 16; i < 32; i++) begin
            access(0, 1'b1, 16'(i * 4), $urandom, 4'hF, "fill0");
        end
        for (int k = 0; k < 40; k++) begin
            logic [15:0] a;
            a = {1'($urandom), 9'd0, 4'($urandom_range(0, 15)), 2'($urandom)} + 16'h0040;
            access(0, 1'($urandom), a, $urandom, 4'($urandom), "rand0");
        end

        // LATENCY=3: fill all 16 words, then continuous requests
        for (int i = 0; i < 16; i++) begin
            access(1, 1'b1, 16'(i * 4), $urandom, 4'hF, "fill1");
        end
        req_a[1] = 1'b1; we_a[1] = 1'b0; addr_a[1] = 16'h0008; be_a[1] = 4'h0;
        for (int k = 0; k < 16; k++) begin
            acc_now = rdy_a[1];
            @(posedge clk); #1;
            if (acc_now) acc_q.push_back(k);
            if (rv_a[1]) begin
                rv_q.push_back(k);
                chk("held/rdata", 64'(rd_a[1]), 64'(m1[2]));
            end
            @(negedge clk);
        end
        req_a[1] = 1'b0;
        last_rd[1] = m1[2];
        chk("held/accepts", 64'(acc_q.size()), 64'd4);
        chk("held/rvalids", 64'(rv_q.size()), 64'd4);
        for (int i = 0; i < acc_q.size() && i < rv_q.size(); i++) begin
            chk("held/accept_spacing", 64'(acc_q[i]), 64'(4 * i));
            chk("held/rvalid_delay", 64'(rv_q[i] - acc_q[i]), 64'd3);
        end

        // Reset during the second BUSY cycle of a write drops it
        old = m1[5];
        req_a[1] = 1'b1; we_a[1] = 1'b1; addr_a[1] = 16'h0014; wd_a[1] = ~old; be_a[1] = 4'hF;
        @(posedge clk); #1;
        req_a[1] = 1'b0;
        chk("rstbusy/ready", 64'(rdy_a[1]), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_a[1] = 1'b0;
        @(posedge clk); #1;
        chk("rstbusy/rvalid", 64'(rv_a[1]), 64'd0);
        chk("rstbusy/rdata", 64'(rd_a[1]), 64'd0);
        @(negedge clk);
        rst_a[1] = 1'b1;
        last_rd[1] = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rstbusy/no_rvalid", 64'(rv_a[1]), 64'd0);
        end
        @(negedge clk);
        access(1, 1'b0, 16'h0014, 32'h0, 4'h0, "rstbusy_rd");
        chk("rstbusy/word_kept", 64'(rd_a[1]), 64'(old));

`ifdef DMEM_DUMP_EN
        // End of execution while a read is in flight, then a throttled dump
        req_a[1] = 1'b1; we_a[1] = 1'b0; addr_a[1] = 16'h001C;
        @(posedge clk); #1;
        req_a[1] = 1'b0;
        @(negedge clk);
        eoe_a[1] = 1'b1;
        @(negedge clk);
        eoe_a[1] = 1'b0;
        n = 0;
        while (rv_a[1] !== 1'b1 && n < 10) begin
            chk("eoe/no_dump_before_rvalid", 64'(dv_a[1]), 64'd0);
            @(posedge clk); #1;
            n++;
        end
        chk("eoe/rvalid", 64'(rv_a[1]), 64'd1);
        chk("eoe/rdata", 64'(rd_a[1]), 64'(m1[7]));
        idx_exp = 0; tog = 1'b1; n = 0;
        while (idx_exp < 16 && n < 100) begin
            @(negedge clk);
            n++;
            chk("dump/valid", 64'(dv_a[1]), 64'd1);
            chk("dump/ready_low", 64'(rdy_a[1]), 64'd0);
            chk("dump/addr", 64'(da_a[1]), 64'(idx_exp * 4));
            chk("dump/data", 64'(dd_a[1]), 64'(m1[idx_exp]));
            dr_a[1] = tog;
            xfer = tog;
            tog = ~tog;
            if (xfer) idx_exp++;
        end
        chk("dump/count", 64'(idx_exp), 64'd16);
        @(negedge clk);
        dr_a[1] = 1'b0;
        chk("done/flag", 64'(done_a[1]), 64'd1);
        chk("done/valid", 64'(dv_a[1]), 64'd0);
        chk("done/ready", 64'(rdy_a[1]), 64'd0);
        eoe_a[1] = 1'b1;
        @(negedge clk);
        eoe_a[1] = 1'b0;
        req_a[1] = 1'b1;
        repeat (3) @(negedge clk);
        req_a[1] = 1'b0;
        chk("done/sticky", 64'(done_a[1]), 64'd1);
        chk("done/ready_sticky", 64'(rdy_a[1]), 64'd0);
        chk("done/no_rvalid", 64'(rv_a[1]), 64'd0);
        rst_a[1] = 1'b0;
        @(negedge clk);
        rst_a[1] = 1'b1;
        @(negedge clk);
        chk("done/reset_clears", 64'(done_a[1]), 64'd0);
        chk("done/reset_ready", 64'(rdy_a[1]), 64'd1);
`else
        // Dump logic absent: event and dump_ready have no effect
        eoe_a[1] = 1'b1; dr_a[1] = 1'b1;
        @(negedge clk);
        eoe_a[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk("nodump/valid", 64'(dv_a[1]), 64'd0);
        chk("nodump/done", 64'(done_a[1]), 64'd0);
        chk("nodump/addr", 64'(da_a[1]), 64'd0);
        chk("nodump/data", 64'(dd_a[1]), 64'd0);
        chk("nodump/ready", 64'(rdy_a[1]), 64'd1);
        dr_a[1] = 1'b0;
        access(1, 1'b0, 16'h001C, 32'h0, 4'h0, "nodump_rd");
`endif
        access(1, 1'b0, 16'h0008, 32'h0, 4'h0, "final_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
